full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered N-bit binary adder with carry-in and carry-out, built as a ripple chain of 1-bit full-adder cells.
- Serves as the arithmetic leaf for datapath blocks.
- The default WIDTH=1 gives the classic 1-bit full adder: sum = a^b^Cin, Cout = majority(a,b,Cin).
- Outputs are registered: one clock of latency, with a valid qualifier.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  qualifies a, b, Cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered result bits [WIDTH-1:0] of a+b+Cin.
- Cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  sum/Cout hold a result produced from a valid input.

Behaviour:
- Reset:
  - rst=1 immediately (asynchronously) forces sum=0, Cout=0, out_valid=0.
  - Outputs stay at these values while rst is high.
  - The first capture happens on the first rising clk edge after rst deasserts.
- Arithmetic:
  - {Cout,sum} = a + b + Cin, computed at WIDTH+1 bits with no truncation of the carry.
  - Unsigned only; no overflow flag.
- Per-bit cell:
  - s_i = a_i ^ b_i ^ c_i.
  - c_{i+1} = (a_i&b_i) | (a_i&c_i) | (b_i&c_i).
  - c_0 = Cin; Cout = c_WIDTH.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 appear on sum/Cout after edge k, with out_valid=1.
- Invalid input:
  - in_valid=0 at an edge: sum/Cout hold their previous values and out_valid goes 0 after that edge.
  - No backpressure; every valid input is accepted.
- Throughput: one result per cycle; back-to-back valid inputs give back-to-back results.
- Boundaries:
  - All-ones a, b with Cin=1 gives sum = all-ones, Cout=1.
  - All zeros gives 0/0.
  - WIDTH=1 must reproduce the 8-row truth table exactly.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 and outputs zero until the next valid capture after reset release.
- No X propagation from reset values; the combinational chain is purely a function of the current inputs.

Decomposition:
- Package full_adder_pkg:
  - localparam FA_DEFAULT_WIDTH=1.
  - localparam FA_MAX_WIDTH=64.
  - A function fa_ref(a,b,cin) returning {cout,sum}, for shared use by RTL assertions and the bench.
- Sub-module full_adder_bit: combinational 1-bit cell (ports a, b, cin, s, cout).
  - Instantiated WIDTH times in a generate loop.
  - The top level adds the output register stage and the valid flop.

Test Plan:
- Reset: assert rst mid-cycle with random inputs -> sum=0, Cout=0, out_valid=0 immediately, without waiting for clk.
- WIDTH=1 exhaustive: drive all 8 (a,b,Cin) combinations with in_valid=1, one per cycle -> one cycle later sum/Cout give 000->0/0, 001->1/0, 010->1/0, 011->0/1, 100->1/0, 101->0/1, 110->0/1, 111->1/1.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, Cin=1 -> sum=8'h00, Cout=1. Then a=8'hFF, b=8'hFF, Cin=1 -> sum=8'hFF, Cout=1.
- Valid gating: a=3, b=4, Cin=0 valid, then next cycle in_valid=0 with a=9 -> result 7 with out_valid=1, then out_valid=0 while sum holds 7.
- Back-to-back streaming (WIDTH=8): 100 random valid vectors on consecutive cycles -> each {Cout,sum} matches fa_ref exactly one cycle later, with no bubbles.
- Reset mid-stream: assert rst between two valid inputs -> pending result is lost, out_valid=0. After release, the next valid input produces a correct result after one cycle.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and a reference add function for the ripple-carry adder.
// fa_ref is wide enough for the largest legal WIDTH; callers use bits [WIDTH:0].
package full_adder_pkg;

    localparam int unsigned FA_DEFAULT_WIDTH = 1;
    localparam int unsigned FA_MAX_WIDTH     = 64;

    // Operands narrower than FA_MAX_WIDTH must be zero-extended; {cout,sum} is then bits [WIDTH:0].
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin
    );
        return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell: one link of the ripple-carry chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry in/out and a valid qualifier.
// One cycle of latency; invalid cycles hold sum/Cout and drop out_valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             out_valid_d;
    logic             out_valid_q;

    assign carry_s[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .s    (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Next-state: capture the chain result on a valid cycle, otherwise hold data and clear valid.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum_s;
            cout_d      = carry_s[WIDTH];
            out_valid_d = 1'b1;
        end else begin
            sum_d       = sum_q;
            cout_d      = cout_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register stage; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench: a WIDTH=1 instance for the truth table and a
// WIDTH=8 instance for ripple, gating, streaming and reset behaviour.
module tb_full_adder;

    logic       clk;
    logic       rst;

    logic       in_valid1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic [0:0] sum1;
    logic       cout1;
    logic       out_valid1;

    logic       in_valid8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8;
    logic       out_valid8;

    int checks;
    int failures;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .Cin       (cin1),
        .sum       (sum1),
        .Cout      (cout1),
        .out_valid (out_valid1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .Cin       (cin8),
        .sum       (sum8),
        .Cout      (cout8),
        .out_valid (out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_valid);
        checks++;
        if (sum8 !== exp_sum) begin
            failures++;
            $display("FAIL %s sum got=%h exp=%h", name, sum8, exp_sum);
        end
        checks++;
        if (cout8 !== exp_cout) begin
            failures++;
            $display("FAIL %s cout got=%b exp=%b", name, cout8, exp_cout);
        end
        checks++;
        if (out_valid8 !== exp_valid) begin
            failures++;
            $display("FAIL %s out_valid got=%b exp=%b", name, out_valid8, exp_valid);
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic c);
        in_valid8 = v;
        a8        = av;
        b8        = bv;
        cin8      = c;
    endtask

    task automatic test_reset();
        // Outputs are zero while reset is held.
        check8("reset_hold", 8'h00, 1'b0, 1'b0);
        checks++;
        if ({sum1, cout1, out_valid1} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold_w1 got=%b exp=000", {sum1, cout1, out_valid1});
        end
        @(negedge clk);
        rst = 1'b0;
        drive8(1'b1, 8'h05, 8'h06, 1'b1);
        @(posedge clk); #1;
        check8("pre_reset_capture", 8'h0C, 1'b0, 1'b1);
        // Assert reset mid-cycle with live inputs; clear must not wait for a clock edge.
        @(negedge clk); #2;
        drive8(1'b1, 8'hA7, 8'h9C, 1'b1);
        rst = 1'b1;
        #1;
        check8("reset_async", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check8("reset_held_edge", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] v;
        exp_s = 8'h96;
        exp_c = 8'hE8;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            in_valid1 = 1'b1;
            a1        = v[2];
            b1        = v[1];
            cin1      = v[0];
            @(posedge clk); #1;
            checks++;
            if ({cout1, sum1, out_valid1} !== {exp_c[i], exp_s[i], 1'b1}) begin
                failures++;
                $display("FAIL truth_table abc=%b got cout,sum,valid=%b%b%b exp=%b%b1",
                         v, cout1, sum1, out_valid1, exp_c[i], exp_s[i]);
            end
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        a1        = 1'b0;
        b1        = 1'b0;
        cin1      = 1'b0;
    endtask

    task automatic test_carry_ripple();
        @(negedge clk);
        drive8(1'b1, 8'hFF, 8'h00, 1'b1);
        @(posedge clk); #1;
        check8("ripple_ff_00_1", 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        check8("ripple_ff_ff_1", 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        drive8(1'b1, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check8("all_zero", 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive8(1'b1, 8'h80, 8'h80, 1'b0);
        @(posedge clk); #1;
        check8("msb_carry", 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_valid_gating();
        @(negedge clk);
        drive8(1'b1, 8'd3, 8'd4, 1'b0);
        @(posedge clk); #1;
        check8("gate_valid", 8'd7, 1'b0, 1'b1);
        @(negedge clk);
        drive8(1'b0, 8'd9, 8'd4, 1'b0);
        @(posedge clk); #1;
        check8("gate_hold", 8'd7, 1'b0, 1'b0);
        @(posedge clk); #1;
        check8("gate_hold2", 8'd7, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] av;
        logic [7:0] bv;
        logic       c;
        logic [8:0] exp9;
        int         errs;
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            av   = 8'($urandom_range(0, 255));
            bv   = 8'($urandom_range(0, 255));
            c    = 1'($urandom_range(0, 1));
            exp9 = {1'b0, av} + {1'b0, bv} + {8'h00, c};
            @(negedge clk);
            drive8(1'b1, av, bv, c);
            @(posedge clk); #1;
            checks++;
            if ({cout8, sum8, out_valid8} !== {exp9, 1'b1}) begin
                failures++;
                errs++;
                if (errs <= 5)
                    $display("FAIL stream k=%0d a=%h b=%h cin=%b got={%b,%h} v=%b exp={%b,%h} v=1",
                             k, av, bv, c, cout8, sum8, out_valid8, exp9[8], exp9[7:0]);
            end
        end
        @(negedge clk);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_stream();
        @(negedge clk);
        drive8(1'b1, 8'h21, 8'h43, 1'b0);
        @(posedge clk); #1;
        check8("mid_first", 8'h64, 1'b0, 1'b1);
        // Second valid input is presented but reset arrives before its capture edge.
        @(negedge clk);
        drive8(1'b1, 8'hF0, 8'h20, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check8("mid_reset_clear", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check8("mid_pending_lost", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive8(1'b1, 8'h7F, 8'h01, 1'b1);
        #1;
        check8("mid_released", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check8("mid_after_release", 8'h81, 1'b0, 1'b1);
        @(negedge clk);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid1 = 1'b0;
        a1        = 1'b0;
        b1        = 1'b0;
        cin1      = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_truth_table();
        test_carry_ripple();
        test_valid_gating();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
